// File: rtl/mips_cpu_fetch_ctrl.sv
// Fetch sequencer between the PC and the instruction-memory port: one read per
// instruction, held through wait states, with MIPS delay-slot redirect and halt on a jump to HALT_ADDR.
module mips_cpu_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        instr_read,
  output logic [31:0] instr_address,
  input  logic        instr_waitrequest,
  input  logic [31:0] instr_readdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  input  logic        core_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic        active,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] target_q, target_d;
  logic        pending_q, pending_d;
  logic        fault_q, fault_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_VECTOR;
      instr_q   <= 32'h0;
      target_q  <= 32'h0;
      pending_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      target_q  <= target_d;
      pending_q <= pending_d;
      fault_q   <= fault_d;
    end
  end

  // NOTE: every next-state signal gets a hold default first, so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    target_d  = target_q;
    pending_d = pending_q;
    fault_d   = fault_q;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        if (!instr_waitrequest) begin
          instr_d = instr_readdata;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (core_ready) begin
          if (!pending_q) begin
            pc_d = pc_q + 32'd4;
            if (redirect) begin
              target_d  = redirect_target;
              pending_d = 1'b1;
              // A misaligned target stops the core before its delay slot is fetched.
              if (redirect_target[1:0] != 2'b00) begin
                fault_d = 1'b1;
                state_d = S_HALT;
              end else begin
                state_d = S_FETCH;
              end
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            // Delay slot retired: redirect is ignored and the saved target takes effect.
            pending_d = 1'b0;
            if (target_q == HALT_ADDR) begin
              pc_d    = HALT_ADDR;
              state_d = S_HALT;
            end else begin
              pc_d    = target_q;
              state_d = S_FETCH;
            end
          end
        end
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_IDLE;
    endcase
  end

  assign instr_read    = (state_q == S_FETCH);
  assign instr_valid   = (state_q == S_ISSUE);
  assign active        = (state_q == S_FETCH) || (state_q == S_ISSUE);
  assign instr_address = pc_q;
  assign pc            = pc_q;
  assign instr         = instr_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_mips_cpu_fetch_ctrl.sv
// Randomized bench for mips_cpu_fetch_ctrl: a transaction-level PC model pushes the
// expected issue order into a queue that a separate monitor pops on every accept.
module tb_mips_cpu_fetch_ctrl;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] HALT_ADDR    = 32'h00000000;

  logic        clk;
  logic        reset;
  logic        instr_read;
  logic [31:0] instr_address;
  logic        instr_waitrequest;
  logic [31:0] instr_readdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic        core_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic        active;
  logic        fault;

  mips_cpu_fetch_ctrl #(
    .RESET_VECTOR(RESET_VECTOR),
    .HALT_ADDR   (HALT_ADDR)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .instr_read       (instr_read),
    .instr_address    (instr_address),
    .instr_waitrequest(instr_waitrequest),
    .instr_readdata   (instr_readdata),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .core_ready       (core_ready),
    .redirect         (redirect),
    .redirect_target  (redirect_target),
    .pc               (pc),
    .active           (active),
    .fault            (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: content is a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3C1D0A5F;
  endfunction

  assign instr_readdata = mem_word(instr_address);

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: program-order view of which addresses must be issued.
  logic [31:0] exp_q[$];
  logic [31:0] m_pc, m_target;
  bit          m_pending, m_halted, m_fault;

  // Stimulus knobs and one-shot directed redirect request.
  int          p_wait, p_stall, p_redir;
  bit          req_valid, req_match;
  logic [31:0] req_pc, req_target;
  bit          mon_en, thru_mode;

  task automatic model_accept();
    logic [31:0] cur;
    logic [31:0] t;
    bit          take;
    cur  = m_pc;
    take = 1'b0;
    t    = 32'h0;
    redirect        = 1'b0;
    redirect_target = $urandom;
    if (!m_pending) begin
      if (req_valid && (!req_match || req_pc == cur)) begin
        take      = 1'b1;
        t         = req_target;
        req_valid = 1'b0;
      end else if ($urandom_range(99) < p_redir) begin
        take = 1'b1;
        t    = RESET_VECTOR + (32'($urandom_range(1, 63)) << 2);
      end
      m_pc = cur + 32'd4;
      if (take) begin
        redirect        = 1'b1;
        redirect_target = t;
        if (t[1:0] != 2'b00) begin
          m_halted = 1'b1;
          m_fault  = 1'b1;
        end else begin
          m_pending = 1'b1;
          m_target  = t;
          exp_q.push_back(m_pc);
        end
      end else begin
        exp_q.push_back(m_pc);
      end
    end else begin
      // Redirect during a delay slot must be ignored, so drive garbage on it.
      redirect  = 1'($urandom_range(1));
      m_pending = 1'b0;
      if (m_target == HALT_ADDR) begin
        m_halted = 1'b1;
        m_pc     = HALT_ADDR;
      end else begin
        m_pc = m_target;
        exp_q.push_back(m_pc);
      end
    end
  endtask

  task automatic drive_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      instr_waitrequest = ($urandom_range(99) < p_wait);
      core_ready        = !($urandom_range(99) < p_stall);
      redirect          = 1'($urandom_range(1));
      redirect_target   = $urandom;
      if (instr_valid && core_ready && !m_halted) model_accept();
    end
  endtask

  task automatic wait_model_halt(input int budget);
    int n;
    n = 0;
    while (!m_halted && n < budget) begin
      drive_cycles(1);
      n++;
    end
    if (!m_halted) begin
      checks++;
      failures++;
      $display("FAIL halt_timeout: got no halt within %0d cycles expected halt", budget);
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    reset             = 1'b1;
    instr_waitrequest = 1'b0;
    core_ready        = 1'b0;
    redirect          = 1'b0;
    redirect_target   = 32'h0;
    #1;
    check("rst_instr_read", {31'h0, instr_read}, 32'h0);
    check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_active", {31'h0, active}, 32'h0);
    check("rst_pc", pc, RESET_VECTOR);
    check("rst_fault", {31'h0, fault}, 32'h0);
    exp_q.delete();
    m_pc      = RESET_VECTOR;
    m_target  = 32'h0;
    m_pending = 1'b0;
    m_halted  = 1'b0;
    m_fault   = 1'b0;
    req_valid = 1'b0;
    exp_q.push_back(RESET_VECTOR);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  // Monitor: compares every accepted instruction and checks hold/stall stability.
  bit          prev_hold, prev_stall;
  logic [31:0] prev_pc, prev_instr, prev_addr;
  int          last_acc;

  always @(negedge clk) begin
    logic [31:0] e;
    #1;
    if (mon_en) begin
      check("addr_eq_pc", instr_address, pc);
      if (prev_hold) begin
        check("hold_valid", {31'h0, instr_valid}, 32'h1);
        check("hold_pc", pc, prev_pc);
        check("hold_instr", instr, prev_instr);
        check("hold_no_read", {31'h0, instr_read}, 32'h0);
      end
      if (prev_stall) begin
        check("stall_read", {31'h0, instr_read}, 32'h1);
        check("stall_addr", instr_address, prev_addr);
        check("stall_instr", instr, prev_instr);
      end
      if (instr_valid && core_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_accept: got pc %h expected no instruction", pc);
        end else begin
          e = exp_q.pop_front();
          check("issue_pc", pc, e);
          check("issue_instr", instr, mem_word(e));
        end
        if (thru_mode && last_acc >= 0) check("throughput_gap", 32'(cyc - last_acc), 32'd2);
        last_acc = cyc;
      end
      prev_hold  = instr_valid && !core_ready;
      prev_stall = instr_read && instr_waitrequest;
      prev_pc    = pc;
      prev_instr = instr;
      prev_addr  = instr_address;
    end else begin
      prev_hold  = 1'b0;
      prev_stall = 1'b0;
      last_acc   = -1;
    end
  end

  task automatic check_halted(input string tag, input logic exp_fault);
    drive_cycles(4);
    check({tag, "_active"}, {31'h0, active}, 32'h0);
    check({tag, "_read"}, {31'h0, instr_read}, 32'h0);
    check({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
    check({tag, "_fault"}, {31'h0, fault}, {31'h0, exp_fault});
    check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] frozen;
    reset = 1'b1;
    instr_waitrequest = 1'b0;
    core_ready = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0;
    mon_en = 1'b0;
    thru_mode = 1'b0;
    last_acc = -1;
    p_wait = 0; p_stall = 0; p_redir = 0;

    // Zero-wait streaming, a redirect with delay slot at BFC00010, then a wrap past FFFFFFFC.
    do_reset();
    thru_mode = 1'b1;
    drive_cycles(1);
    check("active_after_reset", {31'h0, active}, 32'h1);
    req_valid = 1'b1; req_match = 1'b1; req_pc = 32'hBFC00010; req_target = 32'hBFC00080;
    drive_cycles(20);
    req_valid = 1'b1; req_match = 1'b0; req_target = 32'hFFFFFFF8;
    drive_cycles(20);
    thru_mode = 1'b0;

    // Random wait states, back-pressure and redirects, ending in a jump to HALT_ADDR.
    p_wait = 30; p_stall = 30; p_redir = 15;
    drive_cycles(800);
    req_valid = 1'b1; req_match = 1'b0; req_target = HALT_ADDR;
    wait_model_halt(400);
    check_halted("halt_rand", 1'b0);
    check("halt_rand_pc", pc, HALT_ADDR);

    // Directed halt: jump to 0 from BFC00020, delay slot BFC00024 still issued.
    do_reset();
    p_wait = 20; p_stall = 20; p_redir = 0;
    req_valid = 1'b1; req_match = 1'b1; req_pc = 32'hBFC00020; req_target = HALT_ADDR;
    wait_model_halt(400);
    check_halted("halt_dir", 1'b0);
    check("halt_dir_pc", pc, HALT_ADDR);

    // Misaligned target: fault, halt with no delay slot, instr frozen.
    do_reset();
    p_wait = 20; p_stall = 20; p_redir = 10;
    drive_cycles(30);
    req_valid = 1'b1; req_match = 1'b0; req_target = 32'hBFC00082;
    wait_model_halt(400);
    check_halted("fault", 1'b1);
    frozen = instr;
    drive_cycles(5);
    check("fault_instr_frozen", instr, frozen);
    check("fault_sticky", {31'h0, fault}, 32'h1);

    // Reset asserted while a read is stalled in FETCH.
    do_reset();
    p_wait = 100; p_stall = 0; p_redir = 0;
    drive_cycles(3);
    check("pre_reset_read", {31'h0, instr_read}, 32'h1);
    mon_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_read", {31'h0, instr_read}, 32'h0);
    check("midrst_pc", pc, RESET_VECTOR);
    check("midrst_fault", {31'h0, fault}, 32'h0);
    check("midrst_active", {31'h0, active}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
